mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multicycle MIPS control unit: the initiator that drives the datapath ALU's 3-bit operation select and operand muxes, sequences each instruction through fetch/decode/execute/memory/write-back states, and consumes the ALU `zero` flag to resolve branches. It sits beside the datapath, takes the opcode/funct fields from the instruction register, and paces memory accesses with a ready handshake.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the access this cycle.
- `alu_op`  out  3  000 and, 001 or, 010 add, 100 sll (in2<<in1), 110 sub, 111 slt.
- `alu_src_a`  out  2  00 PC, 01 reg A, 10 shamt.
- `alu_src_b`  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `pc_src`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write`  out  1 each  strobes.
- `iord`  out  1  0 address=PC, 1 address=ALUOut.
- `reg_dst`  out  1  0 rt, 1 rd.  `mem_to_reg`  out  1  0 ALUOut, 1 MDR.
- `retire`  out  1  pulse in last cycle of a legal instruction.
- `illegal`  out  1  pulse in DECODE for unsupported opcode/funct.

## Operation
- Supported: R-type (funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x00 sll), lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08.
- Outputs are decoded from the state register only (plus gating by `mem_ready`/`zero` as noted); any output not listed for a state is 0, muxes default 00.
- FETCH: mem_read=1, iord=0, src_a=00, src_b=01, alu_op=add, pc_src=00; ir_write=pc_write=mem_ready. Stay until mem_ready; then DECODE.
- DECODE: src_a=00, src_b=11, add (branch target to ALUOut). Next: lw/sw→MEM_ADDR, R-type legal→EXECUTE, beq→BRANCH, j→JUMP, addi→ADDI_EXEC; else illegal=1 → FETCH.
- MEM_ADDR: src_a=01, src_b=10, add. → MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read=1, iord=1; wait for mem_ready → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1 → FETCH.
- MEM_WRITE: mem_write=1, iord=1; retire=mem_ready; on mem_ready → FETCH.
- EXECUTE: src_a=10 if funct=sll else 01; src_b=00; alu_op from funct → R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1 → FETCH.
- BRANCH: src_a=01, src_b=00, sub, pc_src=01, pc_write=zero, retire=1 → FETCH.
- JUMP: pc_src=10, pc_write=1, retire=1 → FETCH.
- ADDI_EXEC: src_a=01, src_b=10, add → ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1 → FETCH.

## Timing
- Reset: state←FETCH on the clock edge with reset=1; while reset is high all strobes (pc_write, ir_write, mem_read, mem_write, reg_write, retire, illegal) are forced 0, muxes 00, alu_op=000. Reset mid-instruction abandons it; no write strobe may appear in the cycle reset is asserted.
- Cycles from FETCH entry to retire with mem_ready always 1: j 3, beq 3, R-type 4, addi 4, sw 4, lw 5. Each cycle of mem_ready=0 in FETCH/MEM_READ/MEM_WRITE adds one cycle.
- Handshake: mem_read/mem_write held stable with iord until the cycle mem_ready=1; the access completes in that cycle. mem_ready outside those states is ignored.
- illegal and retire never asserted together; each lasts exactly one cycle.

## Structure
- Package `mips_pkg`: ALU op constants, opcode/funct constants, mux-select constants, state enum (4-bit: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB).
- Sub-module `mips_alu_decode`: combinational funct→{alu_op, is_shift, legal}, used in EXECUTE and DECODE legality check.

## Test plan
- Reset held 3 cycles mid-MEM_READ, release → all strobes 0 during reset, FETCH with mem_read=1 the cycle after release.
- R-type add (funct 0x20), mem_ready=1 → EXECUTE alu_op=010 src_a=01; R_WB reg_write=1 reg_dst=1; retire at cycle 4.
- sll (funct 0x00) → EXECUTE src_a=10, alu_op=100; or (0x25) → 001; slt (0x2A) → 111.
- lw with mem_ready low 2 cycles in MEM_READ → mem_read/iord=1 held 3 cycles, retire at cycle 7, mem_to_reg=1.
- beq with zero=1 then zero=0 → pc_write=1 pc_src=01 vs pc_write=0; both retire at cycle 3, alu_op=110.
- opcode 0x3F → illegal=1 in DECODE, no write strobes, FETCH next cycle; j 0x02 → pc_src=10 pc_write=1.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - ALU, opcode, funct and mux-select constants plus the control state enum
package mips_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REG   = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXECUTE,
        S_R_WB,
        S_BRANCH,
        S_JUMP,
        S_ADDI_EXEC,
        S_ADDI_WB
    } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - control unit <-> datapath/memory signal bundle
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [2:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       retire;
    logic       illegal;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_src,
        output pc_write, ir_write, mem_read, mem_write, reg_write,
        output iord, reg_dst, mem_to_reg, retire, illegal
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_src,
        input  pc_write, ir_write, mem_read, mem_write, reg_write,
        input  iord, reg_dst, mem_to_reg, retire, illegal
    );
endinterface

// File: rtl/mips_alu_decode.sv
// rtl/mips_alu_decode.sv - R-type funct to ALU operation, shift flag and legality
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       is_shift,
    output logic       legal
);

    always_comb begin
        alu_op   = ALU_ADD;
        is_shift = 1'b0;
        legal    = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            FN_SLL: begin
                alu_op   = ALU_SLL;
                is_shift = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM driving datapath muxes and strobes
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master bus
);

    state_t     state, state_next;
    logic [2:0] fn_alu_op;
    logic       fn_is_shift;
    logic       fn_legal;

    logic [2:0] alu_op;
    logic [1:0] alu_src_a, alu_src_b, pc_src;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic       iord, reg_dst, mem_to_reg, retire, illegal;

    mips_alu_decode u_alu_decode (
        .funct    (bus.funct),
        .alu_op   (fn_alu_op),
        .is_shift (fn_is_shift),
        .legal    (fn_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        alu_op     = ALU_AND;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        pc_src     = PCSRC_ALU;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                // Speculative branch target goes to ALUOut while the opcode resolves.
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALU_ADD;
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EXEC;
                    OP_RTYPE: begin
                        if (fn_legal) begin
                            state_next = S_EXECUTE;
                        end else begin
                            illegal    = 1'b1;
                            state_next = S_FETCH;
                        end
                    end
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_ADD;
                state_next = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (bus.mem_ready) state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                retire    = bus.mem_ready;
                if (bus.mem_ready) state_next = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a  = fn_is_shift ? SRCA_SHAMT : SRCA_REG;
                alu_op     = fn_alu_op;
                state_next = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_REG;
                alu_op     = ALU_SUB;
                pc_src     = PCSRC_ALUOUT;
                pc_write   = bus.zero;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_ADD;
                state_next = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
        // Reset silences every output in the same cycle, so an abandoned instruction cannot write.
        if (reset) begin
            alu_op     = ALU_AND;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_REG;
            pc_src     = PCSRC_ALU;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            iord       = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            retire     = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign bus.alu_op     = alu_op;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.pc_src     = pc_src;
    assign bus.pc_write   = pc_write;
    assign bus.ir_write   = ir_write;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.reg_write  = reg_write;
    assign bus.iord       = iord;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.retire     = retire;
    assign bus.illegal    = illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for the multicycle MIPS control unit
module tb_mips_multicycle_ctrl;

    localparam logic [9:0] PCW  = 10'b1000000000;
    localparam logic [9:0] IRW  = 10'b0100000000;
    localparam logic [9:0] MRD  = 10'b0010000000;
    localparam logic [9:0] MWR  = 10'b0001000000;
    localparam logic [9:0] RGW  = 10'b0000100000;
    localparam logic [9:0] IORD = 10'b0000010000;
    localparam logic [9:0] RDST = 10'b0000001000;
    localparam logic [9:0] M2R  = 10'b0000000100;
    localparam logic [9:0] RET  = 10'b0000000010;
    localparam logic [9:0] ILL  = 10'b0000000001;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    // stimulus record: {reset, mem_ready, zero, opcode, funct}
    logic [14:0] stim_q[$];
    logic [18:0] exp_q[$];
    logic [18:0] obs;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
                  bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write,
                  bus.iord, bus.reg_dst, bus.mem_to_reg, bus.retire, bus.illegal};

    function automatic logic [18:0] ev(input logic [2:0] op, input logic [1:0] a, b, p,
                                       input logic [9:0] s);
        return {op, a, b, p, s};
    endfunction

    function automatic logic [18:0] fetch_e(input logic mr);
        return ev(3'b010, 2'b00, 2'b01, 2'b00, mr ? (PCW | IRW | MRD) : MRD);
    endfunction

    function automatic logic [18:0] decode_e(input logic ill);
        return ev(3'b010, 2'b00, 2'b11, 2'b00, ill ? ILL : 10'd0);
    endfunction

    task automatic push(input logic rst, mr, z, input logic [5:0] op, fn, input logic [18:0] e);
        stim_q.push_back({rst, mr, z, op, fn});
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        int cyc = 1;
        logic [14:0] s;
        logic [18:0] e;
        push(1, 1, 0, 6'h23, 6'h00, 19'd0);
        push(0, 1, 0, 6'h23, 6'h00, fetch_e(1));
        push(0, 1, 0, 6'h23, 6'h00, decode_e(0));
        push(0, 1, 0, 6'h23, 6'h00, ev(3'b010, 2'b01, 2'b10, 2'b00, 0));
        push(0, 0, 0, 6'h23, 6'h00, ev(3'b000, 2'b00, 2'b00, 2'b00, MRD | IORD));
        push(1, 0, 1, 6'h23, 6'h00, 19'd0);
        push(1, 1, 1, 6'h23, 6'h00, 19'd0);
        push(1, 1, 0, 6'h23, 6'h00, 19'd0);
        push(0, 0, 0, 6'h23, 6'h00, fetch_e(0));
        push(0, 1, 0, 6'h23, 6'h00, fetch_e(1));
        push(0, 1, 0, 6'h23, 6'h00, decode_e(0));
        push(0, 1, 0, 6'h23, 6'h00, ev(3'b010, 2'b01, 2'b10, 2'b00, 0));
        push(0, 1, 0, 6'h23, 6'h00, ev(3'b000, 2'b00, 2'b00, 2'b00, MRD | IORD));
        push(0, 1, 0, 6'h23, 6'h00, ev(3'b000, 2'b00, 2'b00, 2'b00, RGW | M2R | RET));
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, bus.mem_ready, bus.zero, bus.opcode, bus.funct} = s;
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset cyc%0d: got %b want %b", cyc, obs, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        logic [2:0] ops[6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b100};
        logic [1:0] srca[6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        int cyc = 1;
        logic [14:0] s;
        logic [18:0] e;
        for (int i = 0; i < 6; i++) begin
            push(0, 1, 0, 6'h00, fns[i], fetch_e(1));
            push(0, 1, 0, 6'h00, fns[i], decode_e(0));
            push(0, 1, 0, 6'h00, fns[i], ev(ops[i], srca[i], 2'b00, 2'b00, 0));
            push(0, 1, 0, 6'h00, fns[i], ev(3'b000, 2'b00, 2'b00, 2'b00, RGW | RDST | RET));
        end
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, bus.mem_ready, bus.zero, bus.opcode, bus.funct} = s;
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL rtype cyc%0d funct=%h: got %b want %b", cyc, bus.funct, obs, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem();
        int cyc = 1;
        logic [14:0] s;
        logic [18:0] e;
        // lw stalled two cycles in MEM_READ: retire lands on cycle 7
        push(0, 1, 0, 6'h23, 6'h00, fetch_e(1));
        push(0, 1, 0, 6'h23, 6'h00, decode_e(0));
        push(0, 1, 0, 6'h23, 6'h00, ev(3'b010, 2'b01, 2'b10, 2'b00, 0));
        push(0, 0, 0, 6'h23, 6'h00, ev(3'b000, 2'b00, 2'b00, 2'b00, MRD | IORD));
        push(0, 0, 0, 6'h23, 6'h00, ev(3'b000, 2'b00, 2'b00, 2'b00, MRD | IORD));
        push(0, 1, 0, 6'h23, 6'h00, ev(3'b000, 2'b00, 2'b00, 2'b00, MRD | IORD));
        push(0, 1, 0, 6'h23, 6'h00, ev(3'b000, 2'b00, 2'b00, 2'b00, RGW | M2R | RET));
        // sw with one stall in FETCH and one in MEM_WRITE
        push(0, 0, 0, 6'h2B, 6'h00, fetch_e(0));
        push(0, 1, 0, 6'h2B, 6'h00, fetch_e(1));
        push(0, 0, 0, 6'h2B, 6'h00, decode_e(0));
        push(0, 0, 0, 6'h2B, 6'h00, ev(3'b010, 2'b01, 2'b10, 2'b00, 0));
        push(0, 0, 0, 6'h2B, 6'h00, ev(3'b000, 2'b00, 2'b00, 2'b00, MWR | IORD));
        push(0, 1, 0, 6'h2B, 6'h00, ev(3'b000, 2'b00, 2'b00, 2'b00, MWR | IORD | RET));
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, bus.mem_ready, bus.zero, bus.opcode, bus.funct} = s;
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL mem cyc%0d: got %b want %b", cyc, obs, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        int cyc = 1;
        logic [14:0] s;
        logic [18:0] e;
        push(0, 1, 0, 6'h04, 6'h00, fetch_e(1));
        push(0, 1, 0, 6'h04, 6'h00, decode_e(0));
        push(0, 0, 1, 6'h04, 6'h00, ev(3'b110, 2'b01, 2'b00, 2'b01, PCW | RET));
        push(0, 1, 1, 6'h04, 6'h00, fetch_e(1));
        push(0, 1, 1, 6'h04, 6'h00, decode_e(0));
        push(0, 1, 0, 6'h04, 6'h00, ev(3'b110, 2'b01, 2'b00, 2'b01, RET));
        push(0, 1, 0, 6'h02, 6'h00, fetch_e(1));
        push(0, 1, 0, 6'h02, 6'h00, decode_e(0));
        push(0, 0, 0, 6'h02, 6'h00, ev(3'b000, 2'b00, 2'b00, 2'b10, PCW | RET));
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, bus.mem_ready, bus.zero, bus.opcode, bus.funct} = s;
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL branch_jump cyc%0d: got %b want %b", cyc, obs, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        int cyc = 1;
        logic [14:0] s;
        logic [18:0] e;
        push(0, 1, 0, 6'h3F, 6'h20, fetch_e(1));
        push(0, 1, 0, 6'h3F, 6'h20, decode_e(1));
        push(0, 1, 0, 6'h00, 6'h21, fetch_e(1));
        push(0, 1, 0, 6'h00, 6'h21, decode_e(1));
        push(0, 0, 0, 6'h08, 6'h00, fetch_e(0));
        push(0, 1, 0, 6'h08, 6'h00, fetch_e(1));
        push(0, 1, 0, 6'h08, 6'h00, decode_e(0));
        push(0, 1, 0, 6'h08, 6'h00, ev(3'b010, 2'b01, 2'b10, 2'b00, 0));
        push(0, 1, 0, 6'h08, 6'h00, ev(3'b000, 2'b00, 2'b00, 2'b00, RGW | RET));
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, bus.mem_ready, bus.zero, bus.opcode, bus.funct} = s;
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL illegal_addi cyc%0d: got %b want %b", cyc, obs, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 1;
        int retires = 0;
        logic [14:0] s;
        logic [18:0] e;
        push(0, 1, 0, 6'h02, 6'h00, fetch_e(1));
        push(0, 1, 0, 6'h02, 6'h00, decode_e(0));
        push(0, 1, 0, 6'h02, 6'h00, ev(3'b000, 2'b00, 2'b00, 2'b10, PCW | RET));
        push(0, 1, 0, 6'h00, 6'h00, fetch_e(1));
        push(0, 1, 0, 6'h00, 6'h00, decode_e(0));
        push(0, 1, 0, 6'h00, 6'h00, ev(3'b100, 2'b10, 2'b00, 2'b00, 0));
        push(0, 1, 0, 6'h00, 6'h00, ev(3'b000, 2'b00, 2'b00, 2'b00, RGW | RDST | RET));
        push(0, 1, 1, 6'h04, 6'h00, fetch_e(1));
        push(0, 1, 1, 6'h04, 6'h00, decode_e(0));
        push(0, 1, 1, 6'h04, 6'h00, ev(3'b110, 2'b01, 2'b00, 2'b01, PCW | RET));
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, bus.mem_ready, bus.zero, bus.opcode, bus.funct} = s;
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL back_to_back cyc%0d: got %b want %b", cyc, obs, e);
            end
            if (bus.retire === 1'b1) retires++;
            cyc++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (retires !== 3) begin
            n_err++;
            $display("FAIL back_to_back retire_count: got %0d want 3", retires);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_rtype();
        test_mem();
        test_branch_jump();
        test_illegal();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
